// File: rtl/rotater_seq_pkg.sv
// Shared definitions for the multi-step AC/link rotate/shift unit:
// operation codes, controller state encoding and the stepping-op classifier.
package rotater_seq_pkg;

  localparam logic [2:0] ROT_NOP  = 3'b000;
  localparam logic [2:0] ROT_SWAP = 3'b001;
  localparam logic [2:0] ROT_RAL  = 3'b010;
  localparam logic [2:0] ROT_RAR  = 3'b011;
  localparam logic [2:0] ROT_SHL  = 3'b100;
  localparam logic [2:0] ROT_ASR  = 3'b101;
  localparam logic [2:0] ROT_LSR  = 3'b110;
  localparam logic [2:0] ROT_RSV  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  // Ops that consume the step count; everything else completes at load.
  function automatic logic is_stepping(input logic [2:0] op);
    logic r;
    case (op)
      ROT_RAL, ROT_RAR, ROT_SHL, ROT_ASR, ROT_LSR: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rotater_step.sv
// One bit-position step of a rotate/shift op on the {link, acc} pair.
// Non-stepping and reserved codes pass the operands through untouched.
module rotater_step
  import rotater_seq_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic             lnk,
  output logic [WIDTH-1:0] acc_step,
  output logic             lnk_step
);

  // single-step datapath
  always_comb begin
    acc_step = acc;
    lnk_step = lnk;
    case (op)
      ROT_RAL: begin lnk_step = acc[WIDTH-1]; acc_step = {acc[WIDTH-2:0], lnk};          end
      ROT_RAR: begin lnk_step = acc[0];       acc_step = {lnk, acc[WIDTH-1:1]};          end
      ROT_SHL: begin lnk_step = acc[WIDTH-1]; acc_step = {acc[WIDTH-2:0], 1'b0};         end
      ROT_ASR: begin lnk_step = acc[0];       acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]}; end
      ROT_LSR: begin lnk_step = acc[0];       acc_step = {1'b0, acc[WIDTH-1:1]};         end
      default: begin lnk_step = lnk;          acc_step = acc;                            end
    endcase
  end

endmodule

// File: rtl/rotater_seq.sv
// Sequenced multi-step rotate/shift unit: loads AC+L and a count on start,
// performs up to BPC steps per clock, and pulses done when the result is final.
module rotater_seq
  import rotater_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNTW  = 5,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNTW-1:0]  cnt,
  input  logic [WIDTH-1:0] ai,
  input  logic             li,
  input  logic             oe,
  output logic [WIDTH-1:0] ao,
  output logic             lo,
  output logic             busy,
  output logic             done
);

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  acc_r, acc_nxt_s;
  logic              lnk_r, lnk_nxt_s;
  logic [CNTW-1:0]   cnt_r, cnt_nxt_s, take_s;
  logic [2:0]        op_r, op_nxt_s;
  logic              busy_r, done_r;

  logic [BPC:0][WIDTH-1:0] chain_acc_s;
  logic [BPC:0]            chain_lnk_s;

  function automatic logic [WIDTH-1:0] swap_halves(input logic [WIDTH-1:0] a);
    return {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
  endfunction

  assign chain_acc_s[0] = acc_r;
  assign chain_lnk_s[0] = lnk_r;

  // Stages beyond the remaining count bypass, so a short final cycle does exactly cnt steps.
  for (genvar g = 0; g < BPC; g++) begin : g_step
    logic [WIDTH-1:0] step_acc_s;
    logic             step_lnk_s;

    rotater_step #(.WIDTH(WIDTH)) u_step (
      .op       (op_r),
      .acc      (chain_acc_s[g]),
      .lnk      (chain_lnk_s[g]),
      .acc_step (step_acc_s),
      .lnk_step (step_lnk_s)
    );

    assign chain_acc_s[g+1] = (cnt_r > CNTW'(g)) ? step_acc_s : chain_acc_s[g];
    assign chain_lnk_s[g+1] = (cnt_r > CNTW'(g)) ? step_lnk_s : chain_lnk_s[g];
  end

  // steps consumed this cycle: min(BPC, cnt)
  always_comb begin
    if (cnt_r >= CNTW'(BPC)) begin
      take_s = CNTW'(BPC);
    end else begin
      take_s = cnt_r;
    end
  end

  // next-state and datapath load/step selection
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    lnk_nxt_s   = lnk_r;
    cnt_nxt_s   = cnt_r;
    op_nxt_s    = op_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (op == ROT_SWAP) begin
            acc_nxt_s = swap_halves(ai);
          end else begin
            acc_nxt_s = ai;
          end
          lnk_nxt_s = li;
          cnt_nxt_s = cnt;
          op_nxt_s  = op;
          if (is_stepping(op) && (cnt != {CNTW{1'b0}})) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FIN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_nxt_s = chain_acc_s[BPC];
        lnk_nxt_s = chain_lnk_s[BPC];
        cnt_nxt_s = cnt_r - take_s;
        if (cnt_r == take_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state, datapath and status registers; busy/done are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      acc_r   <= {WIDTH{1'b0}};
      lnk_r   <= 1'b0;
      cnt_r   <= {CNTW{1'b0}};
      op_r    <= ROT_NOP;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      lnk_r   <= lnk_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_r    <= op_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_FIN);
    end
  end

  assign ao   = oe ? acc_r : {WIDTH{1'b0}};
  assign lo   = lnk_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_rotater_seq.sv
// Scoreboard bench for rotater_seq: BPC=1 and BPC=2 instances, directed and
// random ops checked against an arithmetic reference model.
module tb_rotater_seq;
  import rotater_seq_pkg::*;

  localparam int W  = 12;
  localparam int CW = 5;
  localparam longint AMASK = (longint'(1) << W) - 1;
  localparam longint RMASK = (longint'(1) << (W + 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start1, start2, li1, li2, oe1, oe2;
  logic [2:0]    op1, op2;
  logic [CW-1:0] cnt1, cnt2;
  logic [W-1:0]  ai1, ai2, ao1, ao2;
  logic          lo1, lo2, busy1, busy2, done1, done2;

  rotater_seq #(.WIDTH(W), .CNTW(CW), .BPC(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .cnt(cnt1), .ai(ai1), .li(li1),
    .oe(oe1), .ao(ao1), .lo(lo1), .busy(busy1), .done(done1));

  rotater_seq #(.WIDTH(W), .CNTW(CW), .BPC(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .cnt(cnt2), .ai(ai2), .li(li2),
    .oe(oe2), .ao(ao2), .lo(lo2), .busy(busy2), .done(done2));

  typedef struct {
    logic [W-1:0] acc;
    logic         lnk;
    logic         oe;
    longint       lat;
    longint       t0;
  } exp_t;

  exp_t   q1[$];
  exp_t   q2[$];
  exp_t   e1, e2;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: whole-operation arithmetic on the N-step result.
  task automatic model(input logic [2:0] op, input int n, input logic [W-1:0] a, input logic l,
                       input int bpc, output logic [W-1:0] ra, output logic rl, output longint lat);
    longint ring, r, s;
    int k;
    bit stepping;
    ra = a;
    rl = l;
    stepping = 1'b0;
    ring = (longint'(l) << W) | longint'(a);
    k = n % (W + 1);
    case (op)
      3'b001: ra = W'(((longint'(a) & ((longint'(1) << (W/2)) - 1)) << (W/2)) | (longint'(a) >> (W/2)));
      3'b010: begin
        stepping = 1'b1;
        r = ((ring << k) | (ring >> (W + 1 - k))) & RMASK;
        ra = W'(r & AMASK); rl = r[W];
      end
      3'b011: begin
        stepping = 1'b1;
        r = ((ring >> k) | (ring << (W + 1 - k))) & RMASK;
        ra = W'(r & AMASK); rl = r[W];
      end
      3'b100: begin
        stepping = 1'b1;
        if (n > 0) begin
          ra = W'((longint'(a) << n) & AMASK);
          if (n <= W) rl = a[W-n]; else rl = 1'b0;
        end
      end
      3'b101: begin
        stepping = 1'b1;
        if (n > 0) begin
          s = longint'(a);
          if (a[W-1]) s = s - (longint'(1) << W);
          ra = W'((s >>> n) & AMASK);
          if (n <= W) rl = a[n-1]; else rl = a[W-1];
        end
      end
      3'b110: begin
        stepping = 1'b1;
        if (n > 0) begin
          ra = W'(longint'(a) >> n);
          if (n <= W) rl = a[n-1]; else rl = 1'b0;
        end
      end
      default: begin ra = a; rl = l; end
    endcase
    if (stepping && n != 0) lat = 1 + (n + bpc - 1) / bpc;
    else lat = 1;
  endtask

  // Issue one op to dut d; poke re-asserts start with different data while busy.
  task automatic run(input int d, input logic [2:0] op, input int n, input logic [W-1:0] a,
                     input logic l, input logic oe, input bit poke);
    exp_t e;
    int k;
    model(op, n, a, l, d, e.acc, e.lnk, e.lat);
    e.oe = oe;
    @(negedge clk);
    e.t0 = cyc;
    if (d == 1) begin
      start1 = 1'b1; op1 = op; cnt1 = CW'(n); ai1 = a; li1 = l; oe1 = oe;
      q1.push_back(e);
    end else begin
      start2 = 1'b1; op2 = op; cnt2 = CW'(n); ai2 = a; li2 = l; oe2 = oe;
      q2.push_back(e);
    end
    @(negedge clk);
    if (poke) begin
      if (d == 1) begin
        chk("busy at second start", longint'(busy1), 1);
        ai1 = ~a; op1 = ROT_NOP; li1 = ~l;
      end else begin
        chk("busy at second start", longint'(busy2), 1);
        ai2 = ~a; op2 = ROT_NOP; li2 = ~l;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    start2 = 1'b0;
    k = 0;
    while (((d == 1) ? q1.size() : q2.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      chk("done timeout", longint'(k), 0);
      if (d == 1) q1.delete(); else q2.delete();
    end
  endtask

  // monitor for the BPC=1 instance
  always @(negedge clk) begin
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        chk("dut1 spurious done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 ao", longint'(ao1), e1.oe ? longint'(e1.acc) : 0);
        chk("dut1 lo", longint'(lo1), longint'(e1.lnk));
        chk("dut1 latency", cyc - e1.t0, e1.lat);
        chk("dut1 busy with done", longint'(busy1), 1);
      end
    end
  end

  // monitor for the BPC=2 instance
  always @(negedge clk) begin
    if (!reset && done2) begin
      if (q2.size() == 0) begin
        chk("dut2 spurious done", 1, 0);
      end else begin
        e2 = q2.pop_front();
        chk("dut2 ao", longint'(ao2), e2.oe ? longint'(e2.acc) : 0);
        chk("dut2 lo", longint'(lo2), longint'(e2.lnk));
        chk("dut2 latency", cyc - e2.t0, e2.lat);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start1 = 1'b0; op1 = 3'b000; cnt1 = '0; ai1 = '0; li1 = 1'b0; oe1 = 1'b1;
    start2 = 1'b0; op2 = 3'b000; cnt2 = '0; ai2 = '0; li2 = 1'b0; oe2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ao", longint'(ao1), 0);
    chk("reset lo", longint'(lo1), 0);
    chk("reset busy", longint'(busy1), 0);
    chk("reset done", longint'(done1), 0);
    reset = 1'b0;

    run(1, ROT_RAL,  1,  12'o4000, 1'b0, 1'b1, 1'b0);
    run(1, ROT_RAR,  13, 12'o0001, 1'b0, 1'b1, 1'b0);
    run(1, ROT_SWAP, 7,  12'o1234, 1'b1, 1'b1, 1'b0);
    run(1, ROT_SWAP, 7,  12'o1234, 1'b1, 1'b0, 1'b0);
    run(1, ROT_ASR,  3,  12'o7770, 1'b0, 1'b1, 1'b0);
    run(1, ROT_LSR,  12, 12'o7777, 1'b0, 1'b1, 1'b0);
    run(1, ROT_SHL,  31, 12'o7777, 1'b1, 1'b1, 1'b0);
    run(1, ROT_RAL,  0,  12'o5252, 1'b1, 1'b1, 1'b0);
    run(1, ROT_RSV,  9,  12'o1357, 1'b1, 1'b1, 1'b0);
    run(1, ROT_RAL,  27, 12'o0421, 1'b1, 1'b1, 1'b1);
    run(2, ROT_SHL,  3,  12'o4001, 1'b0, 1'b1, 1'b1);
    run(2, ROT_RAR,  13, 12'o0001, 1'b1, 1'b1, 1'b0);
    run(2, ROT_ASR,  31, 12'o4000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run(1, 3'($urandom_range(0, 7)), $urandom_range(0, 31), W'($urandom), 1'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 80; i++) begin
      run(2, 3'($urandom_range(0, 7)), $urandom_range(0, 31), W'($urandom), 1'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    // abort a long rotate with reset; no done may follow
    @(negedge clk);
    start1 = 1'b1; op1 = ROT_RAL; cnt1 = CW'(20); ai1 = 12'o7777; li1 = 1'b1; oe1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy before abort", longint'(busy1), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort ao", longint'(ao1), 0);
    chk("abort lo", longint'(lo1), 0);
    chk("abort busy", longint'(busy1), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort busy later", longint'(busy1), 0);

    run(1, ROT_RAR, 2, 12'o0003, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
